// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between an instruction-fetch port and a
// data port. Data wins by default; a starve counter hands the slot to fetch
// after STARVE_MAX consecutive data grants. A busy counter aborts a stuck
// access after TIMEOUT_MAX busy cycles and reports it through bus_err.
module mem_arbiter #(
    parameter int DATA_LEN    = 32,
    parameter int STARVE_MAX  = 4,
    parameter int TIMEOUT_MAX = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [DATA_LEN-1:0] if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_LEN-1:0] if_rdata,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [2:0]          dm_mem_fn,
    input  logic [DATA_LEN-1:0] dm_addr,
    input  logic [DATA_LEN-1:0] dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_LEN-1:0] dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [2:0]          mem_fn,
    output logic [DATA_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_wdata,
    input  logic                mem_ack,
    input  logic [DATA_LEN-1:0] mem_rdata,
    output logic                bus_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int TW = $clog2(TIMEOUT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } state_t;

    state_t        state_r, state_nx;
    logic [SW-1:0] starve_r;
    logic [TW-1:0] busy_cnt_r;
    logic          dm_win_s, if_win_s, done_s, timeout_s;
    logic          if_rvalid_r, dm_rvalid_r, bus_err_r;

    // Arbitration: only in IDLE and never while reset is asserted.
    always_comb begin
        dm_win_s = 1'b0;
        if_win_s = 1'b0;
        if (reset && (state_r == IDLE)) begin
            if (dm_req && !(if_req && (starve_r == SW'(STARVE_MAX)))) begin
                dm_win_s = 1'b1;
            end else if (if_req) begin
                if_win_s = 1'b1;
            end else begin
                dm_win_s = 1'b0;
            end
        end else begin
            dm_win_s = 1'b0;
        end
    end

    // Next-state logic; ack beats timeout when both land in the same cycle.
    always_comb begin
        state_nx  = state_r;
        done_s    = 1'b0;
        timeout_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (dm_win_s) begin
                    state_nx = BUSY_DM;
                end else if (if_win_s) begin
                    state_nx = BUSY_IF;
                end else begin
                    state_nx = IDLE;
                end
            end
            BUSY_IF, BUSY_DM: begin
                if (mem_ack) begin
                    done_s   = 1'b1;
                    state_nx = IDLE;
                end else if (busy_cnt_r == TW'(TIMEOUT_MAX - 1)) begin
                    timeout_s = 1'b1;
                    state_nx  = IDLE;
                end else begin
                    state_nx = state_r;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= state_nx;
    end

    // Busy counter: number of BUSY cycles already spent on the current access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_cnt_r <= '0;
        end else if ((state_r == IDLE) || done_s || timeout_s) begin
            busy_cnt_r <= '0;
        end else begin
            busy_cnt_r <= busy_cnt_r + TW'(1);
        end
    end

    // Starve counter: data grants in a row while fetch keeps asking.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_r <= '0;
        end else if (!if_req || if_win_s) begin
            starve_r <= '0;
        end else if (dm_win_s && (starve_r != SW'(STARVE_MAX))) begin
            starve_r <= starve_r + SW'(1);
        end else begin
            starve_r <= starve_r;
        end
    end

    // Latch the winner's attributes; fetch is always a plain read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_fn    <= 3'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (dm_win_s) begin
            mem_we    <= dm_we;
            mem_fn    <= dm_mem_fn;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
        end else if (if_win_s) begin
            mem_we    <= 1'b0;
            mem_fn    <= 3'd0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
        end else begin
            mem_we    <= mem_we;
        end
    end

    // Response pulses one cycle after completion or timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rvalid_r <= 1'b0;
            dm_rvalid_r <= 1'b0;
            bus_err_r   <= 1'b0;
        end else begin
            if_rvalid_r <= (state_r == BUSY_IF) && (done_s || timeout_s);
            dm_rvalid_r <= (state_r == BUSY_DM) && (done_s || timeout_s);
            bus_err_r   <= timeout_s;
        end
    end

    // Read data holds until the owning port's next response.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            if_rdata <= '0;
            dm_rdata <= '0;
        end else if (state_r == BUSY_IF) begin
            if (done_s)         if_rdata <= mem_rdata;
            else if (timeout_s) if_rdata <= '0;
            else                if_rdata <= if_rdata;
        end else if (state_r == BUSY_DM) begin
            if (done_s)         dm_rdata <= mem_we ? '0 : mem_rdata;
            else if (timeout_s) dm_rdata <= '0;
            else                dm_rdata <= dm_rdata;
        end else begin
            if_rdata <= if_rdata;
        end
    end

    assign if_gnt    = if_win_s;
    assign dm_gnt    = dm_win_s;
    assign mem_req   = (state_r != IDLE);
    assign if_rvalid = if_rvalid_r;
    assign dm_rvalid = dm_rvalid_r;
    assign bus_err   = bus_err_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_LEN, default 32, width of address and data buses.
REQ-002 Parameter STARVE_MAX, default 4, consecutive data grants tolerated while fetch waits.
REQ-003 Parameter TIMEOUT_MAX, default 255, busy-cycle limit before forced abort.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  instruction-fetch read request; held with if_addr until if_gnt.
REQ-007 if_addr  input  DATA_LEN  fetch address.
REQ-008 if_gnt  output  1  fetch request accepted this cycle.
REQ-009 if_rvalid  output  1  one-cycle pulse, fetch data valid.
REQ-010 if_rdata  output  DATA_LEN  fetch read data.
REQ-011 dm_req  input  1  data-port request; held with dm_* attributes until dm_gnt.
REQ-012 dm_we  input  1  1 = store, 0 = load.
REQ-013 dm_mem_fn  input  3  access size/sign code, passed through unchanged.
REQ-014 dm_addr, dm_wdata  input  DATA_LEN each  data address, store data.
REQ-015 dm_gnt  output  1  data request accepted this cycle.
REQ-016 dm_rvalid  output  1  one-cycle pulse, load data valid or store complete.
REQ-017 dm_rdata  output  DATA_LEN  load data; 0 for stores.
REQ-018 mem_req  output  1  request to shared memory; high until mem_ack.
REQ-019 mem_we, mem_fn, mem_addr, mem_wdata  output  1/3/DATA_LEN/DATA_LEN  registered attributes of the granted access.
REQ-020 mem_ack  input  1  memory completed access this cycle.
REQ-021 mem_rdata  input  DATA_LEN  memory read data, valid with mem_ack.
REQ-022 bus_err  output  1  one-cycle pulse with rvalid when access aborted by timeout.

Function
REQ-023 States SHALL be IDLE, BUSY_IF, BUSY_DM.
REQ-024 In IDLE with any request, arbiter SHALL accept exactly one: gnt combinational high that cycle, attributes latched, next state BUSY_IF/BUSY_DM.
REQ-025 Priority SHALL be data over fetch, except fetch wins when starve counter equals STARVE_MAX.
REQ-026 Starve counter SHALL increment (saturating at STARVE_MAX) on each dm grant while if_req high, and clear on if grant or any cycle if_req low.
REQ-027 mem_req SHALL be high every cycle in BUSY_* (first cycle = one after gnt), low in IDLE.
REQ-028 mem_* attributes SHALL be stable throughout BUSY_*; fetch SHALL drive mem_we=0, mem_fn=0, mem_wdata=0.
REQ-029 On mem_ack in BUSY_*, state SHALL return to IDLE; owning port's rvalid SHALL pulse next cycle with rdata = captured mem_rdata (dm_rdata=0 for stores).
REQ-030 A new grant SHALL be possible in the cycle rvalid pulses (one idle mem_req cycle between back-to-back accesses).
REQ-031 rdata outputs SHALL hold last value until next rvalid.
REQ-032 mem_ack in IDLE SHALL be ignored.
REQ-033 Busy counter SHALL count BUSY_* cycles; at TIMEOUT_MAX cycles without ack, state SHALL go IDLE, owner rvalid and bus_err pulse next cycle, rdata = 0.
REQ-034 mem_ack in the same cycle as timeout SHALL take precedence (normal completion, no bus_err).
REQ-035 Never more than one gnt, one rvalid, or one outstanding access at a time.

Reset
REQ-036 reset low SHALL immediately force IDLE, clear counters, and drive all outputs 0, including mid-access (aborted access yields no rvalid).
REQ-037 After reset release, first grant SHALL be possible on the first rising edge.

Verification
REQ-038 Fetch only: if_req, if_addr=0x100; mem_ack 2 cycles after mem_req, mem_rdata=0x00000013 -> if_gnt cycle 0, mem_req cycles 1-2, if_rvalid cycle 3 with if_rdata=0x00000013.
REQ-039 Simultaneous if_req and dm_req (load 0x200) -> dm_gnt first, if_gnt in the cycle dm_rvalid pulses.
REQ-040 Continuous dm_req and if_req, ack 1 cycle -> exactly 4 dm grants, then 1 if grant, pattern repeats.
REQ-041 Store dm_we=1, dm_addr=0x40, dm_wdata=0xDEADBEEF, dm_mem_fn=2 -> mem_* match, dm_rvalid with dm_rdata=0.
REQ-042 No mem_ack for 255 busy cycles -> IDLE, rvalid+bus_err pulse, rdata=0; ack on cycle 255 -> no bus_err.
REQ-043 reset low during BUSY_DM -> mem_req 0 without clock edge, no dm_rvalid; fresh fetch after release completes normally.
